// File: rtl/instr_fetch.sv
// instr_fetch: picoMIPS fetch stage. Drives the external PC's increment and
// relative-branch controls, holds the fetched word in a valid/ready
// instruction register, and counts decoder back-pressure cycles.
module instr_fetch #(
  parameter int Psize = 6,
  parameter int Isize = 20
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [Psize-1:0] pc_in,
  input  logic [Isize-1:0] rom_data,
  output logic             PCincr,
  output logic             PCrelbranch,
  output logic [Psize-1:0] Branchaddr,
  input  logic             br_take,
  input  logic [Psize-1:0] br_target,
  input  logic             halt_req,
  output logic [Isize-1:0] ir,
  output logic [Psize-1:0] ir_pc,
  output logic             ir_valid,
  input  logic             ir_ready,
  output logic [7:0]       stall_cycles
);

  typedef enum logic [1:0] {IDLE, RUN, HALT} state_t;

  state_t state;
  logic   room;

  // ir can take a new word when it is empty or being consumed this cycle
  assign room = !ir_valid || ir_ready;

  // PC commands: only issued in RUN, branch beats fetch, nothing under reset
  always_comb begin
    PCincr      = 1'b0;
    PCrelbranch = 1'b0;
    Branchaddr  = '0;
    if (reset && state == RUN) begin
      if (br_take) begin
        PCrelbranch = 1'b1;
        // PC adds Branchaddr+1, so pre-subtract the 1 to land on br_target
        Branchaddr  = br_target - pc_in - Psize'(1);
      end else if (room) begin
        PCincr = 1'b1;
      end
    end
  end

  // state machine, instruction register and saturating stall counter
  always_ff @(posedge clk) begin
    if (!reset) begin
      state        <= IDLE;
      ir           <= '0;
      ir_pc        <= '0;
      ir_valid     <= 1'b0;
      stall_cycles <= '0;
    end else begin
      if (ir_valid && !ir_ready && stall_cycles != 8'hFF)
        stall_cycles <= stall_cycles + 8'd1;
      case (state)
        IDLE: state <= RUN;
        RUN: begin
          if (br_take) begin
            ir_valid <= 1'b0;
          end else if (room) begin
            ir       <= rom_data;
            ir_pc    <= pc_in;
            ir_valid <= 1'b1;
          end
          if (halt_req) state <= HALT;
        end
        HALT: begin
          // let a pending instruction drain, never refill
          if (ir_valid && ir_ready) ir_valid <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
// tb_instr_fetch: bench for instr_fetch. Owns the program counter and ROM,
// steps the PC from the DUT's commands, and compares every cycle against a
// rule-level model of the fetch stage.
module tb_instr_fetch;
  localparam int P = 6;
  localparam int I = 20;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         reset, br_take, halt_req, ir_ready;
  logic [P-1:0] pc, br_target, Branchaddr, ir_pc;
  logic [I-1:0] rom_data, ir;
  logic         PCincr, PCrelbranch, ir_valid;
  logic [7:0]   stall_cycles;
  logic [I-1:0] rom [64];

  assign rom_data = rom[pc];

  instr_fetch #(.Psize(P), .Isize(I)) dut (
    .clk(clk), .reset(reset), .pc_in(pc), .rom_data(rom_data),
    .PCincr(PCincr), .PCrelbranch(PCrelbranch), .Branchaddr(Branchaddr),
    .br_take(br_take), .br_target(br_target), .halt_req(halt_req),
    .ir(ir), .ir_pc(ir_pc), .ir_valid(ir_valid), .ir_ready(ir_ready),
    .stall_cycles(stall_cycles)
  );

  int nchk = 0, nerr = 0;

  // model: started/running/halted phase, contents of ir, stall count
  int           phase;  // 0 = first cycle after reset, 1 = fetching, 2 = halted
  bit           m_v;
  logic [I-1:0] m_ir;
  logic [P-1:0] m_pc;
  int           m_stall;

  logic         cap_incr, cap_rel;
  logic [P-1:0] cap_ba;

  typedef struct {
    logic [P-1:0] pc, tgt;
    logic         br, rdy, e_inc, e_rel;
    logic [P-1:0] e_ba;
  } vec_t;
  vec_t tbl [6];

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    nchk++;
    if (a !== e) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d", n, a, e);
    end
  endtask

  task automatic check_comb();
    bit run, e_rel, e_inc;
    run   = reset && phase == 1;
    e_rel = run && br_take;
    e_inc = run && !br_take && (!m_v || ir_ready);
    chk("PCincr", PCincr, e_inc);
    chk("PCrelbranch", PCrelbranch, e_rel);
    if (e_rel) chk("branch_lands_on_target", 6'(pc + Branchaddr + 6'd1), br_target);
    else       chk("Branchaddr_idle_zero", Branchaddr, 0);
  endtask

  task automatic check_regs();
    chk("ir_valid", ir_valid, m_v);
    chk("ir", ir, m_ir);
    chk("ir_pc", ir_pc, m_pc);
    chk("stall_cycles", stall_cycles, m_stall);
  endtask

  // one clock: check commands, clock, advance model and PC, check registers
  task automatic cycle();
    logic [P-1:0] pc0;
    #1;
    check_comb();
    cap_incr = PCincr; cap_rel = PCrelbranch; cap_ba = Branchaddr;
    pc0 = pc;
    @(posedge clk);
    #1;
    if (!reset) begin
      phase = 0; m_v = 0; m_ir = '0; m_pc = '0; m_stall = 0;
    end else begin
      if (m_v && !ir_ready && m_stall < 255) m_stall++;
      if (phase == 0) phase = 1;
      else if (phase == 1) begin
        if (br_take) m_v = 0;
        else if (!m_v || ir_ready) begin
          m_ir = rom[pc0]; m_pc = pc0; m_v = 1;
        end
        if (halt_req) phase = 2;
      end else if (m_v && ir_ready) m_v = 0;
    end
    if (!reset)        pc = '0;
    else if (cap_incr) pc = pc0 + 6'd1;
    else if (cap_rel)  pc = pc0 + cap_ba + 6'd1;
    check_regs();
  endtask

  initial begin
    logic [P-1:0] save_pc;
    tbl[0] = '{pc: 6'd9,  tgt: 6'd2,  br: 1, rdy: 1, e_inc: 0, e_rel: 1, e_ba: 6'd56};
    tbl[1] = '{pc: 6'd63, tgt: 6'd0,  br: 1, rdy: 0, e_inc: 0, e_rel: 1, e_ba: 6'd0};
    tbl[2] = '{pc: 6'd0,  tgt: 6'd63, br: 1, rdy: 1, e_inc: 0, e_rel: 1, e_ba: 6'd62};
    tbl[3] = '{pc: 6'd5,  tgt: 6'd5,  br: 1, rdy: 1, e_inc: 0, e_rel: 1, e_ba: 6'd63};
    tbl[4] = '{pc: 6'd10, tgt: 6'd0,  br: 0, rdy: 1, e_inc: 1, e_rel: 0, e_ba: 6'd0};
    tbl[5] = '{pc: 6'd10, tgt: 6'd3,  br: 0, rdy: 0, e_inc: 0, e_rel: 0, e_ba: 6'd0};

    for (int i = 0; i < 64; i++) rom[i] = I'($urandom);
    reset = 0; br_take = 0; br_target = '0; halt_req = 0; ir_ready = 1; pc = '0;
    phase = 0; m_v = 0; m_ir = '0; m_pc = '0; m_stall = 0;

    // reset and startup
    repeat (3) cycle();
    chk("rst_valid", ir_valid, 0);
    chk("rst_stall", stall_cycles, 0);
    reset = 1;
    cycle();
    chk("idle_no_fetch", ir_valid, 0);
    cycle();
    chk("first_incr", cap_incr, 1);
    chk("first_ir", ir, rom[0]);
    chk("first_ir_pc", ir_pc, 0);
    chk("first_valid", ir_valid, 1);

    // streaming
    for (int i = 1; i <= 5; i++) begin
      cycle();
      chk("stream_ir_pc", ir_pc, i);
      chk("stream_stall", stall_cycles, 0);
    end

    // back-pressure at ir_pc=5
    ir_ready = 0;
    repeat (4) begin
      cycle();
      chk("bp_no_incr", cap_incr, 0);
      chk("bp_ir_held", ir, rom[5]);
    end
    chk("bp_stall", stall_cycles, 4);
    ir_ready = 1;
    cycle();
    chk("bp_resume", ir_pc, 6);

    // combinational vectors, no clock edge
    save_pc = pc;
    foreach (tbl[k]) begin
      pc = tbl[k].pc; br_target = tbl[k].tgt; br_take = tbl[k].br; ir_ready = tbl[k].rdy;
      #1;
      chk("tbl_incr", PCincr, tbl[k].e_inc);
      chk("tbl_rel", PCrelbranch, tbl[k].e_rel);
      chk("tbl_ba", Branchaddr, tbl[k].e_ba);
    end
    pc = save_pc; br_take = 0; ir_ready = 1;

    // branch at pc_in=9 to 2
    cycle(); cycle();
    chk("pre_branch_ir_pc", ir_pc, 8);
    br_take = 1; br_target = 6'd2;
    cycle();
    chk("br_ba", cap_ba, 56);
    chk("br_rel", cap_rel, 1);
    chk("br_flush", ir_valid, 0);
    br_take = 0;
    cycle();
    chk("br_target_ir_pc", ir_pc, 2);
    chk("br_target_valid", ir_valid, 1);

    // wrap: go to 63, then branch 63 -> 0
    br_take = 1; br_target = 6'd63;
    cycle();
    br_target = 6'd0;
    cycle();
    chk("wrap_ba", cap_ba, 0);
    chk("wrap_rel", cap_rel, 1);
    br_take = 0;

    // random traffic against the model
    repeat (400) begin
      br_take   = ($urandom_range(0, 6) == 0);
      br_target = P'($urandom);
      ir_ready  = ($urandom_range(0, 3) != 0);
      cycle();
    end

    // branch together with halt
    br_take = 1; br_target = 6'd10; halt_req = 1; ir_ready = 1;
    cycle();
    chk("hb_rel", cap_rel, 1);
    chk("hb_valid", ir_valid, 0);
    halt_req = 0; br_target = 6'd20;
    repeat (5) begin
      cycle();
      chk("halt_no_cmd", {cap_incr, cap_rel}, 0);
    end
    br_take = 0;

    // halt with a pending instruction, stall saturation, drain
    reset = 0;
    cycle();
    chk("rst_mid_stall", stall_cycles, 0);
    reset = 1; ir_ready = 1;
    repeat (3) cycle();
    ir_ready = 0; halt_req = 1;
    cycle();
    halt_req = 0;
    repeat (299) cycle();
    chk("sat_stall", stall_cycles, 255);
    chk("sat_valid", ir_valid, 1);
    ir_ready = 1;
    cycle();
    chk("drain_valid", ir_valid, 0);
    repeat (3) cycle();
    chk("drain_stays", ir_valid, 0);
    chk("halt_ir_pc", ir_pc, 1);
    reset = 0;
    cycle();
    chk("final_rst_stall", stall_cycles, 0);

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end
endmodule

// File: doc/instr_fetch.md
# instr_fetch

Instruction fetch stage for picoMIPS. It sits between the asynchronous program ROM and the decoder, and drives the program counter's increment and relative-branch controls. It holds the fetched instruction in a valid/ready instruction register and flushes it on taken branches. Absolute branch targets from execute are converted into the PC's relative branch operand. It also provides a halt state and a saturating stall counter.

## Interface
- Psize, 6, program address width (up to 64 instructions)
- Isize, 20, instruction width
- clk  in  1  system clock; all state updates on posedge
- reset  in  1  synchronous, active-low reset
- pc_in  in  Psize  current program counter value, which also addresses the ROM
- rom_data  in  Isize  ROM word at pc_in, combinational and valid in the same cycle
- PCincr  out  1  PC increment command (combinational)
- PCrelbranch  out  1  PC relative-branch command (combinational)
- Branchaddr  out  Psize  relative operand; the PC adds Branchaddr+1
- br_take  in  1  execute requests a branch this cycle
- br_target  in  Psize  absolute branch target address
- halt_req  in  1  level; stops fetching permanently until reset
- ir  out  Isize  instruction register
- ir_pc  out  Psize  address that ir was fetched from
- ir_valid  out  1  ir holds an instruction for the decoder
- ir_ready  in  1  decoder consumes ir on a cycle with ir_valid&&ir_ready
- stall_cycles  out  8  count of decoder back-pressure cycles, saturating

## Operation
- **Reset:** when reset==0 at posedge clk:
  - state=IDLE
  - ir=0, ir_pc=0, ir_valid=0, stall_cycles=0
- **Combinational outputs** while reset==0, in IDLE and in HALT: PCincr=0, PCrelbranch=0, Branchaddr=0.
- **States:**
  - IDLE: lasts exactly one cycle after reset release, with no fetch. Then goes to RUN.
  - RUN: normal fetch.
  - HALT: no fetch. The only exit is reset.
- **RUN priority, per cycle:**
  1. **Branch (br_take=1):**
     - PCrelbranch=1, PCincr=0.
     - Branchaddr=(br_target-pc_in-1) mod 2^Psize, so the next PC equals br_target.
     - ir_valid<=0 (flush). ir and ir_pc keep their values.
  2. **Fetch (br_take=0 and (ir_valid==0 or ir_ready==1)):**
     - PCincr=1.
     - ir<=rom_data, ir_pc<=pc_in, ir_valid<=1.
  3. **Hold (otherwise):**
     - PCincr=0, PCrelbranch=0.
     - ir, ir_pc and ir_valid are unchanged.
- **PCincr and PCrelbranch** are never both 1.
- **Branchaddr** equals 0 whenever PCrelbranch=0.
- **halt_req=1 in RUN:** state<=HALT at the next edge. The RUN action of the same cycle still applies, with branch ahead of fetch ahead of hold.
- **HALT:**
  - No PC commands.
  - If ir_valid and ir_ready, then ir_valid<=0. A pending instruction drains and nothing new is fetched.
  - br_take is ignored.
- **stall_cycles:** increments in any state when ir_valid=1 and ir_ready=0. It saturates at 255 and never wraps.
- **Address wrap:** Branchaddr arithmetic is modulo 2^Psize. pc_in=63 with br_target=0 gives Branchaddr=0.

## Timing
- Fetch latency: rom_data at pc_in=N appears on ir one cycle later. At the same edge the PC moves to N+1.
- Throughput: one instruction per cycle while ir_ready=1.
- Branch penalty:
  - Branch asserted in cycle t: PC=br_target at t+1 and ir_valid=0 at t+1.
  - The target instruction is in ir at t+2.
- ir_valid, once set, stays 1 with ir stable until consumed or flushed.
- First fetch after reset release: the first edge loads no instruction (IDLE). The ROM word at address 0 is in ir after the second edge.
- reset==0 mid-operation overrides all other inputs at that edge.

## Test plan
- **Reset/startup:**
  - Stimulus: hold reset=0 for 3 cycles, then release; the PC model starts at 0.
  - Required: ir_valid=0 for 1 cycle after release. ir=ROM[0], ir_pc=0, ir_valid=1 on the next cycle. PCincr=1 in that cycle.
- **Streaming:**
  - Stimulus: ir_ready=1 continuously.
  - Required: ir_pc takes 0,1,2,3 on successive cycles and stall_cycles stays 0.
- **Back-pressure:**
  - Stimulus: drop ir_ready for 4 cycles with ir_pc=5.
  - Required: ir stays ROM[5], PCincr=0, stall_cycles=4. After ir_ready returns, ir_pc=6 on the next cycle.
- **Branch:**
  - Stimulus: br_take=1, br_target=2 at pc_in=9.
  - Required: Branchaddr=56, PCrelbranch=1. ir_valid=0 the next cycle, then ir_pc=2.
- **Wrap and simultaneous events:**
  - Stimulus: br_take=1, br_target=0 at pc_in=63.
  - Required: Branchaddr=0.
  - Stimulus: br_take=1 with halt_req=1.
  - Required: the branch is performed, state goes to HALT, and there are no further PC commands.
- **Halt drain and saturation:**
  - Stimulus: enter HALT with ir_valid=1 and ir_ready=0 for 300 cycles, then ir_ready=1.
  - Required: stall_cycles=255, then ir_valid=0 and stays 0. Reset returns stall_cycles to 0.
